// File: rtl/bar_mem_responder.sv
// Memory-side responder for one bar port: word-addressed single-port RAM behind a
// fixed-latency read pipeline, plus a sticky out-of-range access flag.
module bar_mem_responder #(
    parameter int WIDTH        = 64,
    parameter int LENGTH       = 4096,
    parameter int READ_LATENCY = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_en,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             oob_err
);

    localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic [WIDTH-1:0] mem [LENGTH];
    logic             in_range;
    logic [AW-1:0]    word_idx;

    // Full 32-bit compare so large addresses never alias onto real words.
    assign in_range = (addr < 32'(LENGTH));
    assign word_idx = addr[AW-1:0];

    // RAM contents survive reset; only the commit is suppressed while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (write_en && in_range) begin
            mem[word_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if (!in_range) begin
            oob_err <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : g_ram_read
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= !write_en;
                        if (!write_en) begin
                            data_reg <= in_range ? mem[word_idx] : '0;
                        end
                    end
                end
            end else begin : g_shift
                // Data only moves with a valid slot, so bubbles leave the last word in place.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= g_stage[gi-1].valid_reg;
                        if (g_stage[gi-1].valid_reg) begin
                            data_reg <= g_stage[gi-1].data_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign rd_valid = g_stage[READ_LATENCY-1].valid_reg;
    assign data_out = g_stage[READ_LATENCY-1].data_reg;

endmodule
